// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and
// the baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Rounded clock cycles per bit period.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream handshake from the UART receiver to its consumer:
// data/valid driven by the receiver, ready returned by the consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sync_2ff.sv
// Multi-flop bit synchronizer for asynchronous inputs; the flops reset
// to rst_val_i so an idle line does not look like an edge after reset.
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= {STAGES{rst_val_i}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register on a valid/ready port.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err_o pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      rx_i,
    uart_rx_if.master rx_if,
    output logic      frame_err_o,
    output logic      overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic      parity_err_o,
`endif
    output logic      busy_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 done;
    logic                 accept;
`ifdef UART_RX_PARITY_EN
    logic                 bad_q, bad_d;
    logic                 perr_q, perr_d;
`endif

    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rst_val_i (1'b1),
        .d_i       (rx_i),
        .q_o       (rx_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        bad_d   = bad_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s && rx_prev_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    bad_d   = 1'b0;
`endif
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    // Even parity: line bit must equal XOR of the data bits.
                    if (rx_s != ^shift_q) begin
                        perr_d = 1'b1;
                        bad_d  = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        done    = !bad_q;
`else
                        done    = 1'b1;
`endif
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A byte completing in the accept cycle replaces the old one.
    assign accept = valid_q && rx_if.ready;

    always_comb begin
        valid_d = valid_q && !accept;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (done) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_prev_q <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_prev_q <= rx_s;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bad_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            bad_q  <= bad_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err_o = perr_q;
`endif

    assign rx_if.data  = data_q;
    assign rx_if.valid = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the core's `tx_o` serial output.
- Used in two places:
  - In the SoC as the console/command input path, so the host can download matrices and operands for the systolic-array accelerator.
  - In the system bench, looped onto `riscv_top.tx_o` to decode firmware prints.
- Oversamples `rx_i` with a cycle counter, validates start and stop bits, and presents bytes on a valid/ready interface with a one-entry holding register.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Must be ≥ 8.
- SYNC_STAGES, 2, flops in the `rx_i` metastability synchronizer (≥ 2).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- rx_i  in  1  serial line; idle high
- data_o  out  8  received byte, LSB-first reassembled
- valid_o  out  1  `data_o` holds an unconsumed byte
- ready_i  in  1  consumer accepts the byte when `valid_o && ready_i`
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte dropped because holding register full
- busy_o  out  1  high in every FSM state except IDLE

Behaviour:
- Reset:
  - Reset is asynchronous assert, synchronous release.
  - All outputs go to 0; `data_o` = 8'h00.
  - FSM goes to IDLE, counters to 0, synchronizer flops to 1 (line idle).
- `rx_s` is `rx_i` after SYNC_STAGES flops. All decisions use `rx_s` only.
- FSM states are IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Falling edge detected when `rx_s` = 0 and previous `rx_s` = 1.
  - On that edge, clear the counter and go to START.
- START:
  - Count to CLKS_PER_BIT/2 − 1 (integer division), then sample `rx_s`.
  - If 0, go to DATA with counter and bit index cleared.
  - If 1, treat as a glitch: return to IDLE with no output.
- DATA:
  - Every CLKS_PER_BIT cycles, sample `rx_s` into shift register bit [idx]; bit 0 is first.
  - After idx 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - If 1, the byte completes and the FSM returns to IDLE immediately (mid-stop-bit) to allow resync.
  - If 0, pulse `frame_err_o` for 1 cycle, discard the byte, and go to BREAK.
- BREAK: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from being read as repeated start bits.
- Byte completion and handshake:
  - Empty holding register: load it and set `valid_o` on the next edge. Latency from the stop-bit sample to `valid_o` is 1 cycle.
  - `valid_o` and `data_o` are held stable until `valid_o && ready_i`.
  - `valid_o` clears on the edge after acceptance, unless a new byte completes in that same cycle. In that case the new byte loads, `valid_o` stays 1, and no overrun occurs.
  - Full holding register with no accept in the completion cycle: keep the old byte, drop the new one, pulse `overrun_o` for 1 cycle.
- End-to-end latency: from `rx_i` start-bit falling edge to `valid_o` is SYNC_STAGES + 1 + CLKS_PER_BIT/2 + 8·CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles. Bench tolerance is ±1.
- Mid-frame reset: the frame is abandoned and the FSM is in IDLE after release. It may re-sync on a later data falling edge; such bytes are not checked.
- `ready_i` while `valid_o` = 0 is ignored.

Optional Feature:
- Macro name: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, using one extra bit period.
  - Expects even parity over the 8 data bits.
  - Adds output `parity_err_o` (1 bit), a one-cycle pulse on mismatch.
  - A byte with bad parity is discarded, like a framing error.
  - Frame becomes 8E1 and latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; no PARITY state and no `parity_err_o` port.

Decomposition:
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - DATA_BITS = 8;
  - function `clks_per_bit(clk_hz, baud)`, which is shared with the matching transmitter.
- Sub-module `sync_2ff`: parameterised-depth bit synchronizer with a reset value input. It is reused for other asynchronous inputs.

Test Plan:
- Bench uses CLKS_PER_BIT = 16.
- Single byte: send 8'hA5 as 8N1 with `ready_i` = 1 → `valid_o` pulses 1 cycle, `data_o` = 8'hA5, latency per formula ±1, no error pulses.
- Back-pressure and overrun:
  - Send 8'h3C then 8'hC3 back-to-back with `ready_i` = 0.
  - After the first byte: `valid_o` = 1 holding 8'h3C.
  - At the second byte's stop: `overrun_o` pulses once, `data_o` stays 8'h3C.
  - Then `ready_i` = 1 for 1 cycle → `valid_o` = 0.
- Framing error: send 8'hFF with stop bit forced low and line held low for 40 cycles, then high → `frame_err_o` pulses exactly once, no `valid_o`, next byte 8'h55 is received correctly.
- Glitch rejection: drive `rx_i` low for 4 cycles (< CLKS_PER_BIT/2) → FSM returns to IDLE, no `valid_o`, no error.
- Same-cycle accept and complete: hold 8'h11 unaccepted. Assert `ready_i` exactly in the cycle 8'h22's stop bit is sampled → no overrun, `valid_o` stays 1, `data_o` = 8'h22.
- Integration with reset (CLKS_PER_BIT = 868):
  - Connect to `riscv_top.tx_o`.
  - Assert `rst_ni` low mid-frame for 10 cycles → outputs 0, FSM in IDLE after release.
  - The next byte sent after the line returns idle decodes correctly.
  - With UART_RX_PARITY_EN defined, an even-parity 8'h07 frame with a wrong parity bit → `parity_err_o` pulse, no `valid_o`.
